// File: rtl/add_sub_nbits.sv
// add_sub_nbits: registered ripple-carry adder/subtractor with carry, signed overflow and zero flags.
// Latency: 1 cycle; operands sampled on a clk_i edge show up on the outputs right after that edge.
// Backpressure: none; a new operation is accepted on every cycle that valid_i is high.

// Single-bit full-adder cell, chained LSB to MSB by add_sub_nbits.
module add_sub_nbits_fa (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);

  // Sum and majority carry of three input bits.
  always_comb begin
    s_o = a_i ^ b_i ^ c_i;
    c_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);
  end

endmodule

module add_sub_nbits #(
  parameter int width = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [width-1:0] a_i,
  input  logic [width-1:0] b_i,
  input  logic             sub_i,
  input  logic             valid_i,
  output logic [width-1:0] s_o,
  output logic             cout_o,
  output logic             ovf_o,
  output logic             zero_o,
  output logic             valid_o
);

  // Subtraction is A + ~B + 1: B is inverted and the "+1" enters as carry-in of bit 0.
  logic [width-1:0] b_x;
  logic [width:0]   carry;
  logic [width-1:0] sum;

  // Conditional inversion of B and the chain carry-in.
  always_comb begin
    b_x      = b_i ^ {width{sub_i}};
    carry[0] = sub_i;
  end

  // Ripple chain: carry[i] feeds bit i, carry[i+1] is its carry-out.
  for (genvar i = 0; i < width; i++) begin : g_fa
    add_sub_nbits_fa u_fa (
      .a_i (a_i[i]),
      .b_i (b_x[i]),
      .c_i (carry[i]),
      .s_o (sum[i]),
      .c_o (carry[i+1])
    );
  end

  // Result registers and their next-state values.
  logic [width-1:0] s_q,    s_d;
  logic             cout_q, cout_d;
  logic             ovf_q,  ovf_d;
  logic             zero_q, zero_d;
  logic             valid_q, valid_d;

  // Load a fresh result when valid_i is high; otherwise hold the flags and drop valid.
  // Signed overflow is carry into the MSB disagreeing with carry out of it; for width=1
  // the "carry into the MSB" is the chain carry-in itself.
  always_comb begin
    s_d     = s_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
    valid_d = 1'b0;
    if (valid_i) begin
      s_d     = sum;
      cout_d  = carry[width];
      ovf_d   = carry[width] ^ carry[width-1];
      zero_d  = (sum == '0);
      valid_d = 1'b1;
    end
  end

  // Output registers; reset wins over valid_i and reports a zero result.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s_q     <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b1;
      valid_q <= 1'b0;
    end else begin
      s_q     <= s_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
      valid_q <= valid_d;
    end
  end

  // Outputs come straight from registers, so no input reaches an output combinationally.
  always_comb begin
    s_o     = s_q;
    cout_o  = cout_q;
    ovf_o   = ovf_q;
    zero_o  = zero_q;
    valid_o = valid_q;
  end

endmodule

// File: tb/tb_add_sub_nbits.sv
// Testbench for add_sub_nbits (width=8): directed corner cases plus random back-to-back traffic
// checked against an arithmetic reference model.
module tb_add_sub_nbits;

  localparam int W = 8;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic [W-1:0] a_i;
  logic [W-1:0] b_i;
  logic         sub_i;
  logic         valid_i;
  logic [W-1:0] s_o;
  logic         cout_o;
  logic         ovf_o;
  logic         zero_o;
  logic         valid_o;

  int n_checks = 0;
  int n_fail   = 0;

  add_sub_nbits #(.width(W)) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .a_i     (a_i),
    .b_i     (b_i),
    .sub_i   (sub_i),
    .valid_i (valid_i),
    .s_o     (s_o),
    .cout_o  (cout_o),
    .ovf_o   (ovf_o),
    .zero_o  (zero_o),
    .valid_o (valid_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on unsigned and signed views of the operands.
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                       output logic [W-1:0] s, output logic c, output logic o, output logic z);
    int ua, ub, sa, sb, ur, sr;
    ua = int'(a);
    ub = int'(b);
    sa = (ua >= 128) ? ua - 256 : ua;
    sb = (ub >= 128) ? ub - 256 : ub;
    if (sub) begin
      ur = ua - ub;
      sr = sa - sb;
      c  = (ua >= ub);
    end else begin
      ur = ua + ub;
      sr = sa + sb;
      c  = (ur > 255);
    end
    s = W'(ur & 255);
    o = (sr > 127) || (sr < -128);
    z = (s == '0);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, ".s"},     64'(s_o),     64'h0);
    check({tag, ".cout"},  64'(cout_o),  64'h0);
    check({tag, ".ovf"},   64'(ovf_o),   64'h0);
    check({tag, ".zero"},  64'(zero_o),  64'h1);
    check({tag, ".valid"}, 64'(valid_o), 64'h0);
  endtask

  // Present one operation (called just after an edge), clock it in, then compare.
  task automatic op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                    input logic sub);
    logic [W-1:0] es;
    logic ec, eo, ez;
    model(a, b, sub, es, ec, eo, ez);
    a_i = a; b_i = b; sub_i = sub; valid_i = 1'b1;
    @(posedge clk_i); #1;
    check({tag, ".s"},     64'(s_o),     64'(es));
    check({tag, ".cout"},  64'(cout_o),  64'(ec));
    check({tag, ".ovf"},   64'(ovf_o),   64'(eo));
    check({tag, ".zero"},  64'(zero_o),  64'(ez));
    check({tag, ".valid"}, 64'(valid_o), 64'h1);
  endtask

  initial begin
    logic [W-1:0] ta [6];
    logic [W-1:0] tb [6];
    logic         ts [6];
    logic [W-1:0] exp_s [6];
    logic         exp_c [6];

    rst_i = 1'b1; valid_i = 1'b0; a_i = '0; b_i = '0; sub_i = 1'b0;
    @(posedge clk_i); #1;
    @(posedge clk_i); #1;
    check_reset_state("reset");
    rst_i = 1'b0;

    // Directed vectors with hard-coded sums and carries as an independent anchor.
    ta = '{8'h05, 8'h80, 8'h7F, 8'h05, 8'h03, 8'h80};
    tb = '{8'h03, 8'h80, 8'h01, 8'h03, 8'h05, 8'h01};
    ts = '{1'b0,  1'b0,  1'b0,  1'b1,  1'b1,  1'b1};
    exp_s = '{8'h08, 8'h00, 8'h80, 8'h02, 8'hFE, 8'h7F};
    exp_c = '{1'b0,  1'b1,  1'b0,  1'b1,  1'b0,  1'b1};
    for (int i = 0; i < 6; i++) begin
      op($sformatf("dir%0d", i), ta[i], tb[i], ts[i]);
      check($sformatf("dir%0d.s_const", i),    64'(s_o),    64'(exp_s[i]));
      check($sformatf("dir%0d.cout_const", i), 64'(cout_o), 64'(exp_c[i]));
    end

    // Hold: load 0x08, then idle with different operands.
    op("pre_hold", 8'h05, 8'h03, 1'b0);
    a_i = 8'hFF; b_i = 8'hFF; sub_i = 1'b0; valid_i = 1'b0;
    @(posedge clk_i); #1;
    check("hold.s",     64'(s_o),     64'h08);
    check("hold.cout",  64'(cout_o),  64'h0);
    check("hold.ovf",   64'(ovf_o),   64'h0);
    check("hold.zero",  64'(zero_o),  64'h0);
    check("hold.valid", 64'(valid_o), 64'h0);
    @(posedge clk_i); #1;
    check("hold2.s", 64'(s_o), 64'h08);

    // Reset asserted together with valid operands: operands discarded.
    op("pre_rst", 8'h80, 8'h80, 1'b0);
    rst_i = 1'b1; valid_i = 1'b1; a_i = 8'h7F; b_i = 8'h01; sub_i = 1'b0;
    @(posedge clk_i); #1;
    check_reset_state("rst_valid");
    rst_i = 1'b0;
    op("post_rst", 8'h7F, 8'h01, 1'b0);

    // Random back-to-back operations.
    for (int i = 0; i < 1000; i++) begin
      op($sformatf("rnd%0d", i), W'($urandom_range(0, 255)), W'($urandom_range(0, 255)),
         1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/add_sub_nbits.md
ADD_SUB_NBITS -- requirements
Module: add_sub_nbits

Interface
REQ-001 Parameter: width, default 8, operand/result bit width; legal range 1..64.
REQ-002 clk_i  input  1  sole clock; all state changes on its rising edge.
REQ-003 rst_i  input  1  reset, synchronous, active-high.
REQ-004 a_i  input  width  operand A (unsigned or two's complement).
REQ-005 b_i  input  width  operand B (unsigned or two's complement).
REQ-006 sub_i  input  1  operation select: 0 = A+B, 1 = A-B.
REQ-007 valid_i  input  1  operands valid; sampled on every clock edge.
REQ-008 s_o  output  width  registered result, low width bits of the sum or difference.
REQ-009 cout_o  output  1  registered carry-out of the MSB adder stage.
REQ-010 ovf_o  output  1  registered signed (two's complement) overflow flag.
REQ-011 zero_o  output  1  registered flag, 1 when s_o is all zeros.
REQ-012 valid_o  output  1  registered flag, 1 when s_o/cout_o/ovf_o/zero_o hold a new result.

Function
REQ-013 Datapath: one ripple-carry adder computing A + (B XOR {width{sub_i}}) + sub_i, i.e. subtraction is two's-complement add.
REQ-014 The adder is built from width single-bit full-adder cells chained LSB to MSB; carry-in of bit 0 is sub_i.
REQ-015 s_o equals (a_i + b_i) mod 2^width when sub_i=0 and (a_i - b_i) mod 2^width when sub_i=1.
REQ-016 cout_o equals the carry out of bit width-1.
- Add: cout_o=1 means unsigned overflow.
- Sub: cout_o=1 means no borrow (a_i >= b_i unsigned); cout_o=0 means borrow.
REQ-017 ovf_o equals carry into MSB XOR carry out of MSB.
REQ-018 zero_o is 1 when the registered s_o equals 0.
REQ-019 Latency is exactly 1 cycle: operands sampled at edge N appear on the outputs after edge N.
REQ-020 Edge with valid_i=1: s_o, cout_o, ovf_o and zero_o load the new result, and valid_o=1.
REQ-021 Edge with valid_i=0: s_o, cout_o, ovf_o and zero_o hold their values, and valid_o=0.
REQ-022 Back-to-back valid_i=1 on every cycle gives one result per cycle; no stall, no backpressure.
REQ-023 The block contains no combinational path from any input to any output.
REQ-024 For width=1 the same rules apply; ovf_o = carry-in XOR carry-out of bit 0.

Reset
REQ-025 When rst_i=1 at a rising edge: s_o=0, cout_o=0, ovf_o=0, zero_o=1, valid_o=0.
REQ-026 Reset has priority over valid_i; operands presented during a reset cycle are discarded.
REQ-027 The first edge with rst_i=0 and valid_i=1 produces a normal result.

Verification (width=8)
REQ-028 Reset, then a=0x05, b=0x03, sub=0, valid=1 -> next cycle: s_o=0x08, cout_o=0, ovf_o=0, zero_o=0, valid_o=1.
REQ-029 Add a=0x80, b=0x80, sub=0 -> s_o=0x00, cout_o=1, ovf_o=1, zero_o=1.
- Add a=0x7F, b=0x01, sub=0 -> s_o=0x80, cout_o=0, ovf_o=1.
REQ-030 Sub a=0x05, b=0x03 -> s_o=0x02, cout_o=1.
- Sub a=0x03, b=0x05 -> s_o=0xFE, cout_o=0, ovf_o=0.
- Sub a=0x80, b=0x01 -> s_o=0x7F, cout_o=1, ovf_o=1.
REQ-031 Valid result 0x08 loaded, then valid=0 with a=0xFF, b=0xFF -> s_o stays 0x08 and valid_o=0.
- Assert rst_i together with valid=1 -> all outputs take their reset values (REQ-025).
REQ-032 Random test: 1000 back-to-back random a, b, sub with valid=1 -> every cycle s_o and cout_o match the 9-bit sum of the operands presented one cycle earlier.
- ovf_o matches the sign-rule reference model.
